elevator_car_ctrl: RTL and testbench
====================================

ELEVATOR_CAR_CTRL -- requirements
Module: elevator_car_ctrl

Interface
REQ-001 SHALL have parameter TRAVEL_CYCLES, default 8, clock cycles to travel one level (legal 1..255).
REQ-002 SHALL have parameter DOOR_CYCLES, default 4, clock cycles the door stays open (legal 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port queue  input  8  four 2-bit request entries; head entry is queue[1:0], next is queue[3:2], and so on.
REQ-006 SHALL have port tail  input  3  number of valid entries, 0..4.
REQ-007 SHALL have port stop_at_pos_lvl  input  1  high when pos_lvl matches a queued request (combinational from queue logic).
REQ-008 SHALL have port pos_lvl  output  2  current car level, registered; fed back to queue logic.
REQ-009 SHALL have port moving_up  output  1  high while in MOVE_UP.
REQ-010 SHALL have port moving_down  output  1  high while in MOVE_DOWN.
REQ-011 SHALL have port door_open  output  1  high while in DOOR_OPEN.
REQ-012 SHALL have port arrive  output  1  one-cycle pulse in the cycle after pos_lvl changes.

Function
REQ-013 SHALL implement FSM states IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, with registered one-hot-equivalent outputs decoded from the state.
REQ-014 IDLE SHALL evaluate each cycle with priority: stop_at_pos_lvl=1 -> DOOR_OPEN; else tail=0 -> IDLE; else head>pos_lvl -> MOVE_UP; else head<pos_lvl -> MOVE_DOWN; else (head=pos_lvl) -> DOOR_OPEN.
REQ-015 Tail values 5..7 SHALL be treated as 4 (non-empty).
REQ-016 On entry to MOVE_UP/MOVE_DOWN an 8-bit travel counter SHALL load TRAVEL_CYCLES-1 and decrement each cycle.
REQ-017 In the cycle the travel counter is 0, pos_lvl SHALL increment (MOVE_UP) or decrement (MOVE_DOWN) by 1, and the next state SHALL be IDLE.
REQ-018 Each move SHALL cover exactly one level; a multi-level trip SHALL pass through IDLE between levels so that intermediate queued levels stop the car.
REQ-019 pos_lvl SHALL saturate: no increment at 3, no decrement at 0; FSM SHALL never enter MOVE_UP at level 3 or MOVE_DOWN at level 0.
REQ-020 On entry to DOOR_OPEN a door counter SHALL load DOOR_CYCLES-1; when it reaches 0 the next state SHALL be IDLE.
REQ-021 Queue/tail changes during MOVE_* or DOOR_OPEN SHALL be ignored until the next IDLE cycle.
REQ-022 arrive SHALL be asserted exactly in the IDLE cycle following a pos_lvl update, and never otherwise.
REQ-023 Latency: request at other level with TRAVEL_CYCLES=T, distance d -> door_open rises d*(T+1)+1 cycles after the IDLE cycle that starts the trip.

Reset
REQ-024 rst=1 at a rising edge SHALL force state IDLE, pos_lvl=0, counters=0, moving_up=0, moving_down=0, door_open=0, arrive=0.
REQ-025 Reset asserted mid-move or mid-door SHALL abort immediately with no partial level change.

Configuration
REQ-026 Macro DOOR_HOLD_EN SHALL, when defined, add port door_hold input 1; while door_hold=1 in DOOR_OPEN the door counter SHALL reload DOOR_CYCLES-1 every cycle.
REQ-027 Without DOOR_HOLD_EN the door_hold port SHALL not exist and DOOR_OPEN SHALL last exactly DOOR_CYCLES cycles.

Verification
REQ-028 Reset then idle, tail=0 -> pos_lvl=0, all outputs 0 indefinitely.
REQ-029 T=8, queue[1:0]=2, tail=1, stop low at levels 0,1 -> moving_up 8 cycles, arrive at level 1, moving_up 8 cycles, arrive at level 2; with stop driven high at level 2 -> door_open for 4 cycles, then IDLE.
REQ-030 pos_lvl=3, head=0, tail=1, stop asserted at level 1 -> car moves down, opens door at level 1 first, then continues to 0.
REQ-031 pos_lvl=2, stop_at_pos_lvl=1 in IDLE -> door_open the next cycle, no movement, arrive stays 0.
REQ-032 rst pulsed in the 5th cycle of MOVE_UP from level 1 -> next cycle pos_lvl=0, state IDLE, moving_up=0.
REQ-033 DOOR_HOLD_EN defined, door_hold=1 for 10 cycles in DOOR_OPEN, DOOR_CYCLES=4 -> door_open stays high 10+4 cycles after the initial open.

Source files
------------

// File: rtl/elevator_car_ctrl.sv
// rtl/elevator_car_ctrl.sv - single-car elevator FSM stepping one level per move
// Optional macro DOOR_HOLD_EN adds door_hold to keep the door open while asserted.
module elevator_car_ctrl #(
   parameter int TRAVEL_CYCLES = 8,
   parameter int DOOR_CYCLES   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] queue,
   input  logic [2:0] tail,
   input  logic       stop_at_pos_lvl,
`ifdef DOOR_HOLD_EN
   input  logic       door_hold,
`endif
   output logic [1:0] pos_lvl,
   output logic       moving_up,
   output logic       moving_down,
   output logic       door_open,
   output logic       arrive
);

   typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

   localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
   localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

   state_t     state_q, state_d;
   logic [1:0] pos_q, pos_d;
   logic [7:0] travel_q, travel_d;
   logic [7:0] door_q, door_d;
   logic       arrive_q, arrive_d;
   logic       moving_up_q, moving_down_q, door_open_q;
   logic [1:0] head;
   logic       hold;
   logic       unused_queue_bits;

   assign head              = queue[1:0];
   assign unused_queue_bits = ^queue[7:2];

`ifdef DOOR_HOLD_EN
   assign hold = door_hold;
`else
   assign hold = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      travel_d = travel_q;
      door_d   = door_q;
      arrive_d = 1'b0;
      case (state_q)
         IDLE: begin
            // Only IDLE looks at the queue; every other state ignores it.
            if (stop_at_pos_lvl) begin
               state_d = DOOR_OPEN;
               door_d  = DOOR_LOAD;
            end else if (tail != 3'd0) begin
               if (head > pos_q) begin
                  state_d  = MOVE_UP;
                  travel_d = TRAVEL_LOAD;
               end else if (head < pos_q) begin
                  state_d  = MOVE_DOWN;
                  travel_d = TRAVEL_LOAD;
               end else begin
                  state_d = DOOR_OPEN;
                  door_d  = DOOR_LOAD;
               end
            end
         end
         MOVE_UP: begin
            if (travel_q == 8'd0) begin
               state_d = IDLE;
               if (pos_q != 2'd3) begin
                  pos_d    = pos_q + 2'd1;
                  arrive_d = 1'b1;
               end
            end else begin
               travel_d = travel_q - 8'd1;
            end
         end
         MOVE_DOWN: begin
            if (travel_q == 8'd0) begin
               state_d = IDLE;
               if (pos_q != 2'd0) begin
                  pos_d    = pos_q - 2'd1;
                  arrive_d = 1'b1;
               end
            end else begin
               travel_d = travel_q - 8'd1;
            end
         end
         DOOR_OPEN: begin
            if (hold) begin
               door_d = DOOR_LOAD;
            end else if (door_q == 8'd0) begin
               state_d = IDLE;
            end else begin
               door_d = door_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pos_q         <= 2'd0;
         travel_q      <= 8'd0;
         door_q        <= 8'd0;
         arrive_q      <= 1'b0;
         moving_up_q   <= 1'b0;
         moving_down_q <= 1'b0;
         door_open_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         pos_q         <= pos_d;
         travel_q      <= travel_d;
         door_q        <= door_d;
         arrive_q      <= arrive_d;
         moving_up_q   <= (state_d == MOVE_UP);
         moving_down_q <= (state_d == MOVE_DOWN);
         door_open_q   <= (state_d == DOOR_OPEN);
      end
   end

   assign pos_lvl     = pos_q;
   assign moving_up   = moving_up_q;
   assign moving_down = moving_down_q;
   assign door_open   = door_open_q;
   assign arrive      = arrive_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb/tb_elevator_car_ctrl.sv - self-checking bench for elevator_car_ctrl
// Define DOOR_HOLD_EN to also exercise the door_hold port.
`timescale 1ns/1ps
module tb_elevator_car_ctrl;
   localparam int T = 8;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] queue;
   logic [2:0] tail;
   logic       stop;
   logic [1:0] pos_lvl;
   logic       moving_up, moving_down, door_open, arrive;
`ifdef DOOR_HOLD_EN
   logic       door_hold = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   // Environment: stop is raised by the queue logic when the car sits at a requested level.
   logic [3:0] stop_mask = 4'd0;
   bit         glitch = 1'b0;
   logic       glitch_stop = 1'b0;
   assign stop = glitch ? glitch_stop : stop_mask[pos_lvl];

   always #5 clk = ~clk;

   elevator_car_ctrl #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
      .clk(clk),
      .rst(rst),
      .queue(queue),
      .tail(tail),
      .stop_at_pos_lvl(stop),
`ifdef DOOR_HOLD_EN
      .door_hold(door_hold),
`endif
      .pos_lvl(pos_lvl),
      .moving_up(moving_up),
      .moving_down(moving_down),
      .door_open(door_open),
      .arrive(arrive)
   );

   int         model_pos = 0;
   logic [5:0] exp_q[$];

   function automatic logic [5:0] rec(int p, bit u, bit dn, bit dr, bit ar);
      return {2'(p), u, dn, dr, ar};
   endfunction

   // Expected per-cycle waveform built from trip segments: IDLE, T moving cycles, D door cycles.
   task automatic build_model(input logic [1:0] h, input bit ne_in, input logic [3:0] m);
      int cur;
      bit ne, arr, up;
      logic [3:0] mk;
      cur = model_pos; ne = ne_in; mk = m; arr = 1'b0;
      exp_q.delete();
      for (int it = 0; it < 20; it++) begin
         exp_q.push_back(rec(cur, 0, 0, 0, arr));
         arr = 1'b0;
         if (mk[cur] || (ne && h == cur)) begin
            for (int k = 0; k < D; k++) exp_q.push_back(rec(cur, 0, 0, 1, 0));
            mk[cur] = 1'b0;
            if (h == cur) ne = 1'b0;
         end else if (!ne) begin
            break;
         end else begin
            up = (h > cur);
            for (int k = 0; k < T; k++) exp_q.push_back(rec(cur, up, !up, 0, 0));
            cur = up ? cur + 1 : cur - 1;
            arr = 1'b1;
         end
      end
      exp_q.push_back(rec(cur, 0, 0, 0, 0));
      exp_q.push_back(rec(cur, 0, 0, 0, 0));
      model_pos = cur;
   endtask

   task automatic run_scenario(input logic [1:0] h, input logic [2:0] tl, input logic [3:0] m,
                               input string name);
      logic [5:0] obs, e;
      logic [7:0] q_real;
      logic [2:0] tl_live;
      build_model(h, tl != 3'd0, m);
      @(negedge clk);
      q_real = 8'($urandom);
      q_real[1:0] = h;
      tl_live = tl;
      glitch = 1'b0; queue = q_real; tail = tl_live; stop_mask = m;
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = {pos_lvl, moving_up, moving_down, door_open, arrive};
         e = exp_q[i];
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL %s cycle %0d: got pos=%0d up=%b dn=%b door=%b arr=%b, expected pos=%0d up=%b dn=%b door=%b arr=%b",
                     name, i, obs[5:4], obs[3], obs[2], obs[1], obs[0], e[5:4], e[3], e[2], e[1], e[0]);
         end
         if (e[1]) begin
            stop_mask[e[5:4]] = 1'b0;
            if (e[5:4] == h) tl_live = 3'd0;
         end
         if (e[3:1] != 3'd0) begin
            glitch = 1'b1; glitch_stop = 1'($urandom);
            queue = 8'($urandom); tail = 3'($urandom);
         end else begin
            glitch = 1'b0; queue = q_real; tail = tl_live;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; queue = 8'd0; tail = 3'd0; stop_mask = 4'd0;
      repeat (3) @(negedge clk);
      total++;
      if ({pos_lvl, moving_up, moving_down, door_open, arrive} !== 6'd0) begin
         bad++;
         $display("FAIL reset: got %b expected 000000", {pos_lvl, moving_up, moving_down, door_open, arrive});
      end
      rst = 1'b0;
      model_pos = 0;
   endtask

   task automatic test_idle_empty();
      for (int i = 0; i < 20; i++) begin
         queue = 8'($urandom); tail = 3'd0;
         @(negedge clk);
         total++;
         if ({pos_lvl, moving_up, moving_down, door_open, arrive} !== 6'd0) begin
            bad++;
            $display("FAIL idle_empty cycle %0d: got %b expected 000000", i,
                     {pos_lvl, moving_up, moving_down, door_open, arrive});
         end
      end
   endtask

   task automatic test_directed();
      run_scenario(2'd2, 3'd1, 4'b0100, "climb_0_to_2");
      run_scenario(2'd0, 3'd0, 4'b0100, "stop_in_place");
      run_scenario(2'd3, 3'd5, 4'b0000, "head_route_to_3");
      run_scenario(2'd0, 3'd1, 4'b0010, "intermediate_stop");
   endtask

   task automatic test_mid_move_reset();
      run_scenario(2'd1, 3'd1, 4'b0000, "to_lvl1");
      @(negedge clk);
      queue = 8'b0000_0011; tail = 3'd1; stop_mask = 4'd0; glitch = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if ({pos_lvl, moving_up, moving_down, door_open, arrive} !== 6'b01_1000) begin
         bad++;
         $display("FAIL pre_reset_move: got %b expected 011000", {pos_lvl, moving_up, moving_down, door_open, arrive});
      end
      rst = 1'b1; tail = 3'd0;
      @(negedge clk);
      total++;
      if ({pos_lvl, moving_up, moving_down, door_open, arrive} !== 6'd0) begin
         bad++;
         $display("FAIL mid_move_reset: got %b expected 000000", {pos_lvl, moving_up, moving_down, door_open, arrive});
      end
      rst = 1'b0;
      model_pos = 0;
   endtask

   task automatic test_random();
      logic [1:0] h;
      logic [2:0] tl;
      logic [3:0] m;
      for (int n = 0; n < 30; n++) begin
         h  = 2'($urandom);
         tl = ($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         m  = 4'($urandom) & 4'($urandom);
         run_scenario(h, tl, m, "random");
      end
   endtask

`ifdef DOOR_HOLD_EN
   task automatic test_door_hold();
      int cnt, waitc;
      @(negedge clk);
      tail = 3'd0; glitch = 1'b0;
      stop_mask = 4'd0; stop_mask[model_pos] = 1'b1;
      waitc = 0;
      while (!door_open && waitc < 5) begin
         @(negedge clk);
         waitc++;
      end
      cnt = 0;
      while (door_open && cnt < 40) begin
         cnt++;
         door_hold = (cnt <= 10);
         stop_mask = 4'd0;
         @(negedge clk);
      end
      door_hold = 1'b0;
      total++;
      if (cnt != 10 + D) begin
         bad++;
         $display("FAIL door_hold: door open %0d cycles, expected %0d", cnt, 10 + D);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_idle_empty();
      test_directed();
      test_mid_move_reset();
      test_random();
`ifdef DOOR_HOLD_EN
      test_door_hold();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
